// File: rtl/contagem_regressiva_if.sv
// Command and display bundle between the game controller and the countdown timer.
// The master drives the strobes and load values; the slave returns the BCD digits and status flags.
interface contagem_regressiva_if;
  logic       tick_1s;
  logic       load;
  logic [7:0] min_in;
  logic [7:0] sec_in;
  logic       start;
  logic       pause;
  logic       defuse;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] seg_t;
  logic [3:0] seg_u;
  logic       armed;
  logic       warning;
  logic       exploded;
  logic       defused;
  logic       beep;
  logic       load_err;

  modport master (
    output tick_1s, load, min_in, sec_in, start, pause, defuse,
    input  min_t, min_u, seg_t, seg_u, armed, warning, exploded, defused, beep, load_err
  );

  modport slave (
    input  tick_1s, load, min_in, sec_in, start, pause, defuse,
    output min_t, min_u, seg_t, seg_u, armed, warning, exploded, defused, beep, load_err
  );
endinterface

// File: rtl/contagem_regressiva.sv
// Bomb countdown timer: MM:SS held as four BCD digits, decremented once per tick_1s while armed.
// Command priority per cycle is load > defuse > pause > start > tick_1s; all outputs are registered.
module contagem_regressiva #(
  parameter int WARN_SECS = 10,
  parameter int LOAD_MIN  = 1,
  parameter int LOAD_SEC  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  contagem_regressiva_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_PAUSED   = 3'd2,
    ST_EXPLODED = 3'd3,
    ST_DEFUSED  = 3'd4
  } state_t;

  localparam logic [15:0] RST_TIME = {4'(LOAD_MIN / 10), 4'(LOAD_MIN % 10),
                                      4'(LOAD_SEC / 10), 4'(LOAD_SEC % 10)};
  localparam logic [6:0]  WARN_LIM = 7'(WARN_SECS);

  // A load is only legal when every nibble is a decimal digit and the seconds tens digit is 0..5.
  function automatic logic load_ok(input logic [7:0] mi, input logic [7:0] si);
    logic ok;
    ok = 1'b1;
    if (mi[7:4] > 4'd9) ok = 1'b0;
    else ok = ok;
    if (mi[3:0] > 4'd9) ok = 1'b0;
    else ok = ok;
    if (si[7:4] > 4'd5) ok = 1'b0;
    else ok = ok;
    if (si[3:0] > 4'd9) ok = 1'b0;
    else ok = ok;
    return ok;
  endfunction

  // One-second BCD decrement with the seconds/minutes borrow chain; never called at 00:00.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  state_t      state_r, state_s;
  logic [15:0] time_r, time_s;
  logic        beep_r, beep_s;
  logic        load_err_r, load_err_s;
  logic        armed_r, exploded_r, defused_r, warning_r;
  logic        warn_s;
  logic [6:0]  sec_bin_s;
  logic        active_s;

  // Next state, next digits and single-cycle pulses from the prioritised command set.
  always_comb begin
    state_s    = state_r;
    time_s     = time_r;
    beep_s     = 1'b0;
    load_err_s = 1'b0;
    active_s   = (state_r == ST_ARMED) || (state_r == ST_PAUSED);
    if (bus.load) begin
      // An invalid load still consumes the cycle: nothing lower-priority is acted on.
      if (load_ok(bus.min_in, bus.sec_in)) begin
        time_s  = {bus.min_in, bus.sec_in};
        state_s = ST_IDLE;
      end else begin
        load_err_s = 1'b1;
      end
    end else if (bus.defuse) begin
      if (active_s) state_s = ST_DEFUSED;
      else          state_s = state_r;
    end else if (bus.pause) begin
      if (state_r == ST_ARMED) state_s = ST_PAUSED;
      else                     state_s = state_r;
    end else if (bus.start) begin
      if (((state_r == ST_IDLE) || (state_r == ST_PAUSED)) && (time_r != 16'h0000)) state_s = ST_ARMED;
      else                                                                          state_s = state_r;
    end else if (bus.tick_1s && (state_r == ST_ARMED)) begin
      time_s = time_dec(time_r);
      beep_s = 1'b1;
      if (time_r == 16'h0001) state_s = ST_EXPLODED;
      else                    state_s = state_r;
    end else begin
      state_s = state_r;
    end
  end

  // Warning compare looks at the registered time so the flag trails the digits by one edge.
  always_comb begin
    sec_bin_s = 7'(time_r[7:4]) * 7'd10 + 7'(time_r[3:0]);
    warn_s    = 1'b0;
    if ((state_r == ST_ARMED) && (time_r[15:8] == 8'h00) && (sec_bin_s <= WARN_LIM)) warn_s = 1'b1;
    else                                                                             warn_s = 1'b0;
  end

  // State, digits and every output flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      time_r     <= RST_TIME;
      beep_r     <= 1'b0;
      load_err_r <= 1'b0;
      armed_r    <= 1'b0;
      exploded_r <= 1'b0;
      defused_r  <= 1'b0;
      warning_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      time_r     <= time_s;
      beep_r     <= beep_s;
      load_err_r <= load_err_s;
      armed_r    <= (state_s == ST_ARMED);
      exploded_r <= (state_s == ST_EXPLODED);
      defused_r  <= (state_s == ST_DEFUSED);
      warning_r  <= warn_s;
    end
  end

  assign bus.min_t    = time_r[15:12];
  assign bus.min_u    = time_r[11:8];
  assign bus.seg_t    = time_r[7:4];
  assign bus.seg_u    = time_r[3:0];
  assign bus.armed    = armed_r;
  assign bus.warning  = warning_r;
  assign bus.exploded = exploded_r;
  assign bus.defused  = defused_r;
  assign bus.beep     = beep_r;
  assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_contagem_regressiva.sv
// Self-checking bench for contagem_regressiva: directed scenarios then random commands,
// compared every cycle against a model that keeps remaining time as plain seconds.
module tb_contagem_regressiva;

  localparam int WARN = 10;
  localparam int M_IDLE = 0, M_ARMED = 1, M_PAUSED = 2, M_EXPL = 3, M_DEF = 4;

  logic clk;
  logic reset;
  contagem_regressiva_if bus ();

  contagem_regressiva #(.WARN_SECS(WARN), .LOAD_MIN(1), .LOAD_SEC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int beep_cnt = 0;

  // model state
  int   m_state;
  int   m_rem;
  logic m_warn, m_beep, m_lerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int r);
    int m, s;
    m = r / 60;
    s = r % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic valid_load(input logic [7:0] mi, input logic [7:0] si);
    return (mi[7:4] <= 4'd9) && (mi[3:0] <= 4'd9) && (si[7:4] <= 4'd5) && (si[3:0] <= 4'd9);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_rem   = 60;
    m_warn  = 1'b0;
    m_beep  = 1'b0;
    m_lerr  = 1'b0;
  endtask

  // Applies the currently driven commands to the model for one clock edge.
  task automatic model_step();
    m_warn = (m_state == M_ARMED) && (m_rem <= WARN);
    m_beep = 1'b0;
    m_lerr = 1'b0;
    if (bus.load) begin
      if (valid_load(bus.min_in, bus.sec_in)) begin
        m_rem = (int'(bus.min_in[7:4]) * 10 + int'(bus.min_in[3:0])) * 60
              + int'(bus.sec_in[7:4]) * 10 + int'(bus.sec_in[3:0]);
        m_state = M_IDLE;
      end else begin
        m_lerr = 1'b1;
      end
    end else if (bus.defuse) begin
      if (m_state == M_ARMED || m_state == M_PAUSED) m_state = M_DEF;
    end else if (bus.pause) begin
      if (m_state == M_ARMED) m_state = M_PAUSED;
    end else if (bus.start) begin
      if ((m_state == M_IDLE || m_state == M_PAUSED) && m_rem != 0) m_state = M_ARMED;
    end else if (bus.tick_1s && m_state == M_ARMED) begin
      m_rem  = m_rem - 1;
      m_beep = 1'b1;
      if (m_rem == 0) m_state = M_EXPL;
    end
  endtask

  task automatic check_outs();
    chk("digits", {bus.min_t, bus.min_u, bus.seg_t, bus.seg_u}, to_bcd(m_rem));
    chk("flags", {bus.armed, bus.warning, bus.exploded, bus.defused, bus.beep, bus.load_err},
        {m_state == M_ARMED, m_warn, m_state == M_EXPL, m_state == M_DEF, m_beep, m_lerr});
    if (bus.beep) beep_cnt++;
  endtask

  task automatic cmd(input logic ld, input logic df, input logic ps, input logic st, input logic tk,
                     input logic [7:0] mi, input logic [7:0] si);
    bus.load = ld; bus.defuse = df; bus.pause = ps; bus.start = st; bus.tick_1s = tk;
    bus.min_in = mi; bus.sec_in = si;
    model_step();
    @(posedge clk);
    #1;
    check_outs();
    bus.load = 1'b0; bus.defuse = 1'b0; bus.pause = 1'b0; bus.start = 1'b0; bus.tick_1s = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask
  task automatic do_load(input logic [7:0] mi, input logic [7:0] si);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mi, si);
  endtask
  task automatic do_start();
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  function automatic logic [15:0] shown();
    return {bus.min_t, bus.min_u, bus.seg_t, bus.seg_u};
  endfunction

  initial begin
    logic [7:0] mi, si;
    logic ld, df, ps, st, tk;
    int v;
    reset = 1'b0;
    bus.load = 1'b0; bus.defuse = 1'b0; bus.pause = 1'b0; bus.start = 1'b0; bus.tick_1s = 1'b0;
    bus.min_in = 8'h00; bus.sec_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: reset defaults
    chk("rst_digits", 32'(shown()), 32'h0100);
    chk("rst_flags", {bus.armed, bus.warning, bus.exploded, bus.defused, bus.beep, bus.load_err}, 32'h0);
    idle(1);

    // 2: short countdown to explosion
    do_load(8'h00, 8'h03);
    do_start();
    beep_cnt = 0;
    tick(1); chk("t2_02", 32'(shown()), 32'h0002);
    idle(1);
    tick(1); chk("t2_01", 32'(shown()), 32'h0001);
    tick(1); chk("t2_00", 32'(shown()), 32'h0000);
    chk("t2_expl", 32'(bus.exploded), 32'h1);
    chk("t2_armed", 32'(bus.armed), 32'h0);
    tick(2);
    chk("t2_beeps", 32'(beep_cnt), 32'd3);
    chk("t2_hold", 32'(shown()), 32'h0000);

    // 3: borrow chain
    do_load(8'h10, 8'h00); do_start(); tick(1);
    chk("t3_0959", 32'(shown()), 32'h0959);
    do_load(8'h01, 8'h00); do_start(); tick(1);
    chk("t3_0059", 32'(shown()), 32'h0059);

    // 4: warning window and pause
    do_load(8'h00, 8'h12); do_start();
    tick(1); idle(2); chk("t4_warn11", 32'(bus.warning), 32'h0);
    tick(1); idle(2); chk("t4_warn10", 32'(bus.warning), 32'h1);
    tick(5); chk("t4_05", 32'(shown()), 32'h0005);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(1); chk("t4_pwarn", 32'(bus.warning), 32'h0);
    tick(2); chk("t4_frozen", 32'(shown()), 32'h0005);
    do_start(); tick(1); chk("t4_resume", 32'(shown()), 32'h0004);

    // 5: invalid load and start at zero
    do_load(8'h00, 8'h65);
    chk("t5_lerr", 32'(bus.load_err), 32'h1);
    chk("t5_keep", 32'(shown()), 32'h0004);
    do_load(8'h00, 8'h00); do_start();
    chk("t5_zero_start", 32'(bus.armed), 32'h0);

    // 6: same-cycle conflicts and async reset
    do_load(8'h00, 8'h01); do_start();
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("t6_def", 32'(bus.defused), 32'h1);
    chk("t6_digits", 32'(shown()), 32'h0001);
    chk("t6_nobeep", 32'(bus.beep), 32'h0);
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h30);
    chk("t6_ldstart", 32'(bus.armed), 32'h0);
    do_start(); tick(3);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_dig", 32'(shown()), 32'h0100);
    chk("t6_async_flg", {bus.armed, bus.warning, bus.exploded, bus.defused, bus.beep, bus.load_err}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);

    // random phase
    for (int n = 0; n < 4000; n++) begin
      ld = ($urandom_range(0, 99) < 3);
      df = ($urandom_range(0, 99) < 1);
      ps = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 6);
      tk = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 3) == 0) begin
        mi = 8'($urandom);
        si = 8'($urandom);
      end else begin
        v  = $urandom_range(0, 2);
        mi = {4'd0, 4'(v)};
        v  = $urandom_range(0, 59);
        si = {4'(v / 10), 4'(v % 10)};
      end
      if (ld && !valid_load(mi, si)) begin
        df = 1'b0; ps = 1'b0; st = 1'b0; tk = 1'b0;
      end
      cmd(ld, df, ps, st, tk, mi, si);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
